// File: rtl/hack_loader_pkg.sv
// Shared definitions for the UART boot loader: FSM states, protocol bytes
// and a helper that tells which states are guarded by the idle timeout.
package hack_loader_pkg;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        LEN_HI  = 4'd1,
        LEN_LO  = 4'd2,
        DATA_HI = 4'd3,
        DATA_LO = 4'd4,
        WRITE   = 4'd5,
        CHECK   = 4'd6,
        REPLY   = 4'd7,
        DONE    = 4'd8,
        ERROR   = 4'd9
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK       = 8'h06;
    localparam logic [7:0] NAK       = 8'h15;

    // Only the mid-transfer states may time out waiting for the host.
    function automatic logic timer_active(input state_t s);
        return (s == LEN_HI) || (s == LEN_LO) || (s == DATA_HI) ||
               (s == DATA_LO) || (s == WRITE) || (s == CHECK);
    endfunction

endpackage

// File: rtl/loader_timeout.sv
// Idle-clock counter: cleared by each received byte, counts while enabled
// and flags expiry once TIMEOUT_CYCLES idle clocks have elapsed.
module loader_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign o_expired = (count_q == LIMIT);

    // The counter saturates at the limit so expiry stays asserted until cleared.
    always_comb begin
        count_d = count_q;
        if (i_clear || !i_enable) begin
            count_d = '0;
        end else if (!o_expired) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/hack_loader.sv
// UART boot loader: parses a sync/length/data/checksum frame, writes each
// word into ROM with a one-cycle strobe and answers the host with ACK/NAK.
module hack_loader
    import hack_loader_pkg::*;
#(
    parameter int unsigned ROM_WORDS      = 1001,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        i_reset,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_byte,
    input  logic        i_tx_ready,
    output logic        o_tx_valid,
    output logic [7:0]  o_tx_byte,
    output logic [15:0] o_pc,
    output logic [15:0] o_rom,
    output logic        o_bus_cs,
    output logic        o_run,
    output logic        o_error
);

    state_t      state_q, state_d;
    logic [7:0]  cks_q, cks_d;
    logic [15:0] len_q, len_d;
    logic [15:0] idx_q, idx_d;
    logic [7:0]  hi_q, hi_d;
    logic        pend_valid_q, pend_valid_d;
    logic [7:0]  pend_byte_q, pend_byte_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] rom_q, rom_d;
    logic        bus_cs_q, bus_cs_d;
    logic        run_q, run_d;
    logic        error_q, error_d;

    logic        in_valid;
    logic [7:0]  in_byte;
    logic [15:0] new_len;
    logic [15:0] next_idx;
    logic        expired;

    // A byte parked while in WRITE is consumed ahead of any live byte.
    assign in_valid = pend_valid_q | i_rx_valid;
    assign in_byte  = pend_valid_q ? pend_byte_q : i_rx_byte;
    assign new_len  = {len_q[15:8], in_byte};
    assign next_idx = idx_q + 16'd1;

    loader_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .i_reset  (i_reset),
        .i_clear  (i_rx_valid),
        .i_enable (timer_active(state_q)),
        .o_expired(expired)
    );

    always_comb begin
        state_d      = state_q;
        cks_d        = cks_q;
        len_d        = len_q;
        idx_d        = idx_q;
        hi_d         = hi_q;
        pend_valid_d = 1'b0;
        pend_byte_d  = pend_byte_q;
        tx_valid_d   = tx_valid_q;
        tx_byte_d    = tx_byte_q;
        pc_d         = pc_q;
        rom_d        = rom_q;
        bus_cs_d     = 1'b0;
        run_d        = run_q;
        error_d      = error_q;

        if (state_q == WRITE) begin
            if (i_rx_valid) begin
                pend_valid_d = 1'b1;
                pend_byte_d  = i_rx_byte;
            end else begin
                pend_valid_d = pend_valid_q;
            end
        end else if (pend_valid_q && i_rx_valid) begin
            pend_valid_d = 1'b1;
            pend_byte_d  = i_rx_byte;
        end

        case (state_q)
            IDLE, ERROR: begin
                if (in_valid && in_byte == SYNC_BYTE) begin
                    state_d = LEN_HI;
                    cks_d   = 8'h00;
                    idx_d   = 16'h0000;
                    error_d = 1'b0;
                end
            end
            LEN_HI: begin
                if (in_valid) begin
                    len_d   = {in_byte, 8'h00};
                    cks_d   = cks_q ^ in_byte;
                    state_d = LEN_LO;
                end else if (expired) begin
                    state_d    = REPLY;
                    tx_valid_d = 1'b1;
                    tx_byte_d  = NAK;
                end
            end
            LEN_LO: begin
                if (in_valid) begin
                    len_d = new_len;
                    cks_d = cks_q ^ in_byte;
                    if ({16'h0000, new_len} > ROM_WORDS) begin
                        state_d    = REPLY;
                        tx_valid_d = 1'b1;
                        tx_byte_d  = NAK;
                    end else if (new_len == 16'h0000) begin
                        state_d = CHECK;
                    end else begin
                        state_d = DATA_HI;
                    end
                end else if (expired) begin
                    state_d    = REPLY;
                    tx_valid_d = 1'b1;
                    tx_byte_d  = NAK;
                end
            end
            DATA_HI: begin
                if (in_valid) begin
                    hi_d    = in_byte;
                    cks_d   = cks_q ^ in_byte;
                    state_d = DATA_LO;
                end else if (expired) begin
                    state_d    = REPLY;
                    tx_valid_d = 1'b1;
                    tx_byte_d  = NAK;
                end
            end
            DATA_LO: begin
                // Strobe is registered here so it is high exactly while in WRITE.
                if (in_valid) begin
                    cks_d    = cks_q ^ in_byte;
                    pc_d     = idx_q;
                    rom_d    = {hi_q, in_byte};
                    bus_cs_d = 1'b1;
                    state_d  = WRITE;
                end else if (expired) begin
                    state_d    = REPLY;
                    tx_valid_d = 1'b1;
                    tx_byte_d  = NAK;
                end
            end
            WRITE: begin
                idx_d   = next_idx;
                state_d = (next_idx == len_q) ? CHECK : DATA_HI;
            end
            CHECK: begin
                if (in_valid) begin
                    state_d    = REPLY;
                    tx_valid_d = 1'b1;
                    tx_byte_d  = (in_byte == cks_q) ? ACK : NAK;
                end else if (expired) begin
                    state_d    = REPLY;
                    tx_valid_d = 1'b1;
                    tx_byte_d  = NAK;
                end
            end
            REPLY: begin
                if (i_tx_ready) begin
                    tx_valid_d = 1'b0;
                    if (tx_byte_q == ACK) begin
                        state_d = DONE;
                        run_d   = 1'b1;
                    end else begin
                        state_d = ERROR;
                        error_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q      <= IDLE;
            cks_q        <= 8'h00;
            len_q        <= 16'h0000;
            idx_q        <= 16'h0000;
            hi_q         <= 8'h00;
            pend_valid_q <= 1'b0;
            pend_byte_q  <= 8'h00;
            tx_valid_q   <= 1'b0;
            tx_byte_q    <= 8'h00;
            pc_q         <= 16'h0000;
            rom_q        <= 16'h0000;
            bus_cs_q     <= 1'b0;
            run_q        <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cks_q        <= cks_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            hi_q         <= hi_d;
            pend_valid_q <= pend_valid_d;
            pend_byte_q  <= pend_byte_d;
            tx_valid_q   <= tx_valid_d;
            tx_byte_q    <= tx_byte_d;
            pc_q         <= pc_d;
            rom_q        <= rom_d;
            bus_cs_q     <= bus_cs_d;
            run_q        <= run_d;
            error_q      <= error_d;
        end
    end

    assign o_tx_valid = tx_valid_q;
    assign o_tx_byte  = tx_byte_q;
    assign o_pc       = pc_q;
    assign o_rom      = rom_q;
    assign o_bus_cs   = bus_cs_q;
    assign o_run      = run_q;
    assign o_error    = error_q;

endmodule
